// File: rtl/systolic_ws_pkg.sv
// Shared types and constants for the weight-stationary systolic tile.
package systolic_ws_pkg;

  // Tile control states: streaming, flushing in-flight vectors, weight swap.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAccWidth  = 4 * DefDataWidth;

  typedef logic signed [DefDataWidth-1:0] data_t;
  typedef logic signed [DefAccWidth-1:0]  acc_t;

  // Cycles from input handshake to the matching result on the output.
  function automatic int unsigned tile_latency(input int unsigned length,
                                               input int unsigned col_num);
    return length + col_num;
  endfunction

endpackage

// File: rtl/systolic_ws_mac_pe.sv
// One weight-stationary MAC cell: x moves east, partial sums move south.
module systolic_ws_mac_pe
  import systolic_ws_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  input  logic                  wt_wr,
  input  logic [DATA_WIDTH-1:0] wt_data,
  input  logic                  swap,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [ACC_WIDTH-1:0]  psum_out
);

  logic [DATA_WIDTH-1:0]          x_q;
  logic [DATA_WIDTH-1:0]          wt_act_q;
  logic [DATA_WIDTH-1:0]          wt_shd_q;
  logic [ACC_WIDTH-1:0]           psum_q;
  logic signed [2*DATA_WIDTH-1:0] x_ext;
  logic signed [2*DATA_WIDTH-1:0] w_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Full-width signed product, then sign-extended into the accumulator width.
  assign x_ext = (2*DATA_WIDTH)'($signed(x_in));
  assign w_ext = (2*DATA_WIDTH)'($signed(wt_act_q));
  assign prod  = x_ext * w_ext;

  // Pipeline registers and the active/shadow weight pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      psum_q   <= '0;
      wt_act_q <= '0;
      wt_shd_q <= '0;
    end else begin
      x_q    <= x_in;
      psum_q <= psum_in + ACC_WIDTH'(prod);
      if (wt_wr) wt_shd_q <= wt_data;
      // Active takes the shadow value held before any same-cycle write.
      if (swap) wt_act_q <= wt_shd_q;
    end
  end

  assign x_out    = x_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/systolic_ws_tile.sv
// Weight-stationary GEMM tile: input skew, PE grid, output deskew, commit FSM.
module systolic_ws_tile
  import systolic_ws_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 4 * DATA_WIDTH,
  parameter int unsigned LENGTH     = 8,
  parameter int unsigned COL_NUM    = 8,
  localparam int unsigned ROW_ADDR_WIDTH = $clog2(LENGTH)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_rdy,
  input  logic [0:LENGTH-1][DATA_WIDTH-1:0]    in_data,
  input  logic                                 wt_wr_en,
  input  logic [ROW_ADDR_WIDTH-1:0]            wt_wr_row,
  input  logic [0:COL_NUM-1][DATA_WIDTH-1:0]   wt_wr_data,
  input  logic                                 wt_commit,
  output logic                                 wt_busy,
  output logic                                 out_valid,
  output logic [0:COL_NUM-1][ACC_WIDTH-1:0]    out_data
);

  localparam int unsigned Lat      = tile_latency(LENGTH, COL_NUM);
  localparam int unsigned CntWidth = $clog2(Lat);

  state_e                             state_q, state_d;
  logic [CntWidth-1:0]                cnt_q, cnt_d;
  logic                               fire;
  logic                               swap;
  logic [Lat-2:0]                     vld_q;
  logic                               out_valid_q;
  logic [0:COL_NUM-1][ACC_WIDTH-1:0]  out_data_q;

  logic [DATA_WIDTH-1:0] x_h  [LENGTH][COL_NUM+1];
  logic [ACC_WIDTH-1:0]  ps_v [LENGTH+1][COL_NUM];
  logic [ACC_WIDTH-1:0]  y_al [COL_NUM];
  logic [LENGTH-1:0]     unused_x_east;

  assign in_rdy  = !reset && (state_q == RUN);
  assign wt_busy = !reset && (state_q != RUN);
  assign fire    = in_valid && in_rdy;
  assign swap    = (state_q == SWAP);

  // Commit sequencing: drain Lat cycles under old weights, then a one-cycle swap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (wt_commit) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == CntWidth'(Lat - 1)) state_d = SWAP;
        else                             cnt_d   = cnt_q + CntWidth'(1);
      end
      SWAP:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM state and drain counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Input skew: row r sees its element r cycles late; idle cycles inject zeros.
  for (genvar r = 0; r < LENGTH; r++) begin : g_skew
    logic [DATA_WIDTH-1:0] x_gated;
    assign x_gated = fire ? in_data[r] : '0;
    if (r == 0) begin : g_direct
      assign x_h[r][0] = x_gated;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] sk_q [r];
      // Row skew shift register.
      always_ff @(posedge clk) begin
        if (reset) begin
          sk_q <= '{default: '0};
        end else begin
          sk_q[0] <= x_gated;
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign x_h[r][0] = sk_q[r-1];
    end
    assign unused_x_east[r] = ^x_h[r][COL_NUM];
  end

  for (genvar c = 0; c < COL_NUM; c++) begin : g_top
    assign ps_v[0][c] = '0;
  end

  for (genvar r = 0; r < LENGTH; r++) begin : g_row
    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
      systolic_ws_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_pe (
        .clk      (clk),
        .reset    (reset),
        .x_in     (x_h[r][c]),
        .psum_in  (ps_v[r][c]),
        .wt_wr    (wt_wr_en && (wt_wr_row == ROW_ADDR_WIDTH'(r))),
        .wt_data  (wt_wr_data[c]),
        .swap     (swap),
        .x_out    (x_h[r][c+1]),
        .psum_out (ps_v[r+1][c])
      );
    end
  end

  // Output deskew: earlier columns wait so a whole vector lines up.
  for (genvar c = 0; c < COL_NUM; c++) begin : g_dsk
    localparam int unsigned D = COL_NUM - 1 - c;
    if (D == 0) begin : g_direct
      assign y_al[c] = ps_v[LENGTH][c];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] dk_q [D];
      // Column deskew shift register.
      always_ff @(posedge clk) begin
        if (reset) begin
          dk_q <= '{default: '0};
        end else begin
          dk_q[0] <= ps_v[LENGTH][c];
          for (int i = 1; i < int'(D); i++) dk_q[i] <= dk_q[i-1];
        end
      end
      assign y_al[c] = dk_q[D-1];
    end
  end

  // Valid tag follows the vector; the final stage is the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vld_q       <= {vld_q[Lat-3:0], fire};
      out_valid_q <= vld_q[Lat-2];
      if (vld_q[Lat-2]) begin
        for (int unsigned c = 0; c < COL_NUM; c++) out_data_q[c] <= y_al[c];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_systolic_ws_tile.sv
// Scoreboard bench for systolic_ws_tile with a dot-product reference model.
module tb_systolic_ws_tile;
  import systolic_ws_pkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int LN = 4;
  localparam int CN = 4;
  localparam int L  = LN + CN;

  typedef logic [0:LN-1][DW-1:0] xv_t;
  typedef logic [0:CN-1][DW-1:0] wv_t;
  typedef logic [0:CN-1][AW-1:0] yv_t;
  typedef struct {
    int  due;
    yv_t y;
  } exp_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_rdy, wt_wr_en, wt_commit, wt_busy, out_valid;
  xv_t  in_data;
  logic [1:0] wt_wr_row;
  wv_t  wt_wr_data;
  yv_t  out_data;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_end = -1;
  int   swap_cyc = -1;
  int   act [LN][CN];
  int   shd [LN][CN];
  exp_t exp_q [$];
  yv_t  last_y = '0;

  systolic_ws_tile #(
    .DATA_WIDTH (DW),
    .ACC_WIDTH  (AW),
    .LENGTH     (LN),
    .COL_NUM    (CN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .wt_wr_en   (wt_wr_en),
    .wt_wr_row  (wt_wr_row),
    .wt_wr_data (wt_wr_data),
    .wt_commit  (wt_commit),
    .wt_busy    (wt_busy),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [AW*CN-1:0] got, input logic [AW*CN-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, got, want);
    end
  endtask

  function automatic yv_t ref_y(input xv_t x);
    yv_t    y;
    longint s;
    for (int c = 0; c < CN; c++) begin
      s = 0;
      for (int r = 0; r < LN; r++) s += longint'($signed(x[r])) * longint'(act[r][c]);
      y[c] = s[AW-1:0];
    end
    return y;
  endfunction

  function automatic xv_t mkx(input int a, input int b, input int c, input int d);
    xv_t x;
    x[0] = DW'(a); x[1] = DW'(b); x[2] = DW'(c); x[3] = DW'(d);
    return x;
  endfunction

  function automatic xv_t rndx();
    xv_t x;
    for (int i = 0; i < LN; i++) x[i] = DW'($urandom);
    return x;
  endfunction

  function automatic wv_t rndw();
    wv_t w;
    for (int i = 0; i < CN; i++) w[i] = DW'($urandom);
    return w;
  endfunction

  function automatic wv_t row_fill(input int v);
    wv_t w;
    for (int i = 0; i < CN; i++) w[i] = DW'(v);
    return w;
  endfunction

  function automatic wv_t row_diag(input int r, input int v);
    wv_t w;
    for (int i = 0; i < CN; i++) w[i] = (i == r) ? DW'(v) : '0;
    return w;
  endfunction

  // One clock cycle of stimulus; the model tracks expected readiness and weights.
  task automatic step(input bit v, input xv_t x, input bit we, input int row, input wv_t wd,
                      input bit cm);
    bit rdy_exp;
    rdy_exp = (cyc > busy_end);
    chk("in_rdy", in_rdy, rdy_exp);
    chk("wt_busy", wt_busy, !rdy_exp);
    if (cyc == swap_cyc) act = shd;
    in_valid   = v;
    in_data    = x;
    wt_wr_en   = we;
    wt_wr_row  = 2'(row);
    wt_wr_data = wd;
    wt_commit  = cm;
    if (v && rdy_exp) exp_q.push_back('{due: cyc + L, y: ref_y(x)});
    if (we) for (int c = 0; c < CN; c++) shd[row][c] = int'($signed(wd[c]));
    if (cm && rdy_exp) begin
      busy_end = cyc + L + 1;
      swap_cyc = cyc + L + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 0, '0, 1'b0);
  endtask

  task automatic wait_rdy();
    for (int k = 0; k < 40 && cyc <= busy_end; k++) idle(1);
  endtask

  task automatic load_set(input bit diag, input int v, input bit commit);
    for (int r = 0; r < LN; r++) step(1'b0, '0, 1'b1, r, diag ? row_diag(r, v) : row_fill(v), 1'b0);
    if (commit) begin
      step(1'b0, '0, 1'b0, 0, '0, 1'b1);
      wait_rdy();
    end
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    in_valid  = 1'b0;
    wt_wr_en  = 1'b0;
    wt_commit = 1'b0;
    // Results due after the reset edge are lost.
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    #1;
    for (int i = 0; i < n; i++) begin
      chk("in_rdy_in_reset", in_rdy, 1'b0);
      chk("wt_busy_in_reset", wt_busy, 1'b0);
      @(posedge clk);
      #1;
      last_y = '0;
    end
    reset    = 1'b0;
    busy_end = -1;
    swap_cyc = -1;
    for (int r = 0; r < LN; r++)
      for (int c = 0; c < CN; c++) begin
        act[r][c] = 0;
        shd[r][c] = 0;
      end
    #1;
    chk("in_rdy_after_reset", in_rdy, 1'b1);
    chk("out_valid_after_reset", out_valid, 1'b0);
    chk("out_data_after_reset", out_data, '0);
  endtask

  // Monitor: pops the scoreboard whenever the tile presents a result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_output: got none at cycle %0d want %h", exp_q[0].due, exp_q[0].y);
        void'(exp_q.pop_front());
      end
      if (out_valid !== 1'b0) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output at cycle %0d: got out_valid=%b want 0", cyc, out_valid);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.y);
          last_y = e.y;
        end
      end else begin
        chk("out_hold", out_data, last_y);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    wt_wr_en   = 1'b0;
    wt_wr_row  = '0;
    wt_wr_data = '0;
    wt_commit  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Identity weights.
    load_set(1'b1, 1, 1'b1);
    step(1'b1, mkx(1, 2, 3, 4), 1'b0, 0, '0, 1'b0);
    idle(3);

    // All -1 weights, back-to-back signed vectors, then gappy traffic.
    load_set(1'b0, -1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, mkx(127, -128, 5, -6), 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'($urandom_range(1)), rndx(), 1'b0, 0, '0, 1'b0);
    idle(2);

    // Largest-magnitude products.
    load_set(1'b0, -128, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, mkx(-128, -128, -128, -128), 1'b0, 0, '0, 1'b0);

    // Commit under traffic: I active, 2I in shadow; second commit during drain.
    load_set(1'b1, 1, 1'b1);
    load_set(1'b1, 2, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, rndx(), 1'b0, 0, '0, k == 3);
    for (int k = 0; k < 40 && cyc <= busy_end; k++) step(1'b1, rndx(), 1'b0, 0, '0, k == 3);
    for (int k = 0; k < 4; k++) step(1'b1, rndx(), 1'b0, 0, '0, 1'b0);

    // Shadow writes during drain and during the swap cycle.
    step(1'b1, rndx(), 1'b0, 0, '0, 1'b1);
    for (int k = 0; k < 40 && cyc <= busy_end; k++) begin
      if (cyc == swap_cyc)  step(1'b0, '0, 1'b1, 1, row_fill(5), 1'b0);
      else if (k == 2)      step(1'b0, '0, 1'b1, 0, row_fill(3), 1'b0);
      else                  step(1'b0, '0, 1'b0, 0, '0, 1'b0);
    end
    for (int k = 0; k < 3; k++) step(1'b1, rndx(), 1'b0, 0, '0, 1'b0);
    step(1'b0, '0, 1'b0, 0, '0, 1'b1);
    wait_rdy();
    for (int k = 0; k < 3; k++) step(1'b1, rndx(), 1'b0, 0, '0, 1'b0);

    // Random traffic, weight writes and commits.
    for (int i = 0; i < 300; i++)
      step($urandom_range(3) != 0, rndx(), $urandom_range(3) == 0, int'($urandom_range(LN - 1)),
           rndw(), $urandom_range(24) == 0);
    wait_rdy();

    // Reset with vectors in flight.
    for (int k = 0; k < 3; k++) step(1'b1, rndx(), 1'b0, 0, '0, 1'b0);
    do_reset(1);
    for (int k = 0; k < 4; k++) step(1'b1, rndx(), 1'b0, 0, '0, 1'b0);

    for (int k = 0; k < 40 && exp_q.size() > 0; k++) idle(1);
    idle(2);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
